// File: rtl/au_sequencer.sv
// Command-level sequencer for the 8-bit four-function AU: turns keypad commands into AU strobes.
// Optional divide-by-zero rejection is built when AU_DIV_ZERO_CHECK_EN is defined.
module au_sequencer #(
  parameter int MULT_LAT = 10,
  parameter int DIV_LAT  = 20,
  parameter int CNT_W    = 5
) (
  input  logic        Clock,
  input  logic        Clear_n,
  input  logic        CmdValid,
  input  logic [2:0]  Cmd,
  input  logic [1:0]  CmdOp,
  input  logic [15:0] keyOut,
  output logic        Ahigh_in,
  output logic        Alow_in,
  output logic        LoadB,
  output logic        LoadResult,
  output logic        Start,
  output logic        ClearEntry,
  output logic        Clear,
  output logic [1:0]  Operations,
  output logic        Busy,
  output logic        ResultValid,
  output logic        Error
);

  typedef enum logic [2:0] {
    ENTRY = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    LOAD  = 3'd3,
    SHOW  = 3'd4
  } state_t;

  localparam logic [2:0] CMD_LOAD_AH = 3'd0;
  localparam logic [2:0] CMD_LOAD_AL = 3'd1;
  localparam logic [2:0] CMD_LOAD_B  = 3'd2;
  localparam logic [2:0] CMD_SET_OP  = 3'd3;
  localparam logic [2:0] CMD_EQUALS  = 3'd4;
  localparam logic [2:0] CMD_CE      = 3'd5;
  localparam logic [2:0] CMD_CLR     = 3'd6;
  localparam logic [2:0] CMD_RSVD    = 3'd7;

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             a_set_r;
  logic             b_set_r;
  logic             op_set_r;
  logic             operands_ready_s;
  logic             div_zero_s;

  assign operands_ready_s = a_set_r & b_set_r & op_set_r;

`ifdef AU_DIV_ZERO_CHECK_EN
  logic b_zero_r;
  logic unused_key_s;
  assign div_zero_s   = (Operations == 2'b11) & b_zero_r;
  assign unused_key_s = ^keyOut[15:8];
`else
  logic unused_key_s;
  assign div_zero_s   = 1'b0;
  assign unused_key_s = ^keyOut;
`endif

  // Command acceptance, latency wait and registered AU control outputs
  always_ff @(posedge Clock) begin
    if (!Clear_n) begin
      state_r     <= ENTRY;
      cnt_r       <= CNT_ZERO;
      a_set_r     <= 1'b0;
      b_set_r     <= 1'b0;
      op_set_r    <= 1'b0;
`ifdef AU_DIV_ZERO_CHECK_EN
      b_zero_r    <= 1'b0;
`endif
      Operations  <= 2'b00;
      Ahigh_in    <= 1'b0;
      Alow_in     <= 1'b0;
      LoadB       <= 1'b0;
      LoadResult  <= 1'b0;
      Start       <= 1'b0;
      Busy        <= 1'b0;
      ResultValid <= 1'b0;
      Error       <= 1'b0;
      Clear       <= 1'b1;
      ClearEntry  <= 1'b1;
    end else begin
      Ahigh_in   <= 1'b0;
      Alow_in    <= 1'b0;
      LoadB      <= 1'b0;
      LoadResult <= 1'b0;
      Start      <= 1'b0;
      ClearEntry <= 1'b0;
      Clear      <= 1'b0;
      Error      <= 1'b0;
      case (state_r)
        ENTRY, SHOW: begin
          if (CmdValid) begin
            case (Cmd)
              CMD_LOAD_AH: begin
                Ahigh_in    <= 1'b1;
                state_r     <= ENTRY;
                ResultValid <= 1'b0;
              end
              CMD_LOAD_AL: begin
                Alow_in     <= 1'b1;
                a_set_r     <= 1'b1;
                state_r     <= ENTRY;
                ResultValid <= 1'b0;
              end
              CMD_LOAD_B: begin
                LoadB       <= 1'b1;
                b_set_r     <= 1'b1;
`ifdef AU_DIV_ZERO_CHECK_EN
                b_zero_r    <= (keyOut[7:0] == 8'h00);
`endif
                state_r     <= ENTRY;
                ResultValid <= 1'b0;
              end
              CMD_SET_OP: begin
                Operations  <= CmdOp;
                op_set_r    <= 1'b1;
                state_r     <= ENTRY;
                ResultValid <= 1'b0;
              end
              CMD_CE: begin
                ClearEntry  <= 1'b1;
                a_set_r     <= 1'b0;
                b_set_r     <= 1'b0;
                state_r     <= ENTRY;
                ResultValid <= 1'b0;
              end
              CMD_EQUALS: begin
                if (!operands_ready_s || div_zero_s) begin
                  Error <= 1'b1;
                end else if (Operations[1]) begin
                  state_r     <= START;
                  Start       <= 1'b1;
                  cnt_r       <= Operations[0] ? DIV_CNT : MULT_CNT;
                  Busy        <= 1'b1;
                  ResultValid <= 1'b0;
                end else begin
                  state_r     <= LOAD;
                  LoadResult  <= 1'b1;
                  Busy        <= 1'b1;
                  ResultValid <= 1'b0;
                end
              end
              default: begin
              end
            endcase
          end
        end
        START: state_r <= WAIT;
        WAIT: begin
          if (cnt_r == CNT_ONE) begin
            state_r    <= LOAD;
            LoadResult <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        LOAD: begin
          state_r     <= SHOW;
          Busy        <= 1'b0;
          ResultValid <= 1'b1;
        end
        default: begin
          state_r     <= ENTRY;
          Busy        <= 1'b0;
          ResultValid <= 1'b0;
        end
      endcase
      if (CmdValid && (Cmd == CMD_RSVD)) begin
        Error <= 1'b1;
      end
      // CLR wins over everything, including a wait that expires this cycle
      if (CmdValid && (Cmd == CMD_CLR)) begin
        state_r     <= ENTRY;
        cnt_r       <= CNT_ZERO;
        a_set_r     <= 1'b0;
        b_set_r     <= 1'b0;
        op_set_r    <= 1'b0;
`ifdef AU_DIV_ZERO_CHECK_EN
        b_zero_r    <= 1'b0;
`endif
        Clear       <= 1'b1;
        ClearEntry  <= 1'b1;
        Start       <= 1'b0;
        LoadResult  <= 1'b0;
        Busy        <= 1'b0;
        ResultValid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/au_sequencer.md
Name: au_sequencer

Overview:
- Command-level controller that sequences the 8-bit four-function arithmetic unit (AU) from decoded keypad commands.
- Generates the AU's single-cycle load strobes (Ahigh_in, Alow_in, LoadB, LoadResult), its Start pulse, its ClearEntry/Clear controls and the Operations select.
- The AU's multiplier and divider completion flags are internal to the AU, so this block waits a fixed, parameterised cycle count before loading the result.
- Sits between the keypad decoder and the AU.

Parameters:
- MULT_LAT, 10: cycles from the end of the Start pulse until the AU multiplier product is stable.
- DIV_LAT, 20: cycles from the end of the Start pulse until the AU divider quotient/remainder are stable.
- CNT_W, 5: wait-counter width; must satisfy 2^CNT_W > max(MULT_LAT, DIV_LAT).

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Clear_n  in  1  synchronous active-low reset.
- CmdValid  in  1  one-cycle command strobe from the keypad decoder.
- Cmd  in  3  command code: 0 LOAD_AH, 1 LOAD_AL, 2 LOAD_B, 3 SET_OP, 4 EQUALS, 5 CE, 6 CLR, 7 reserved.
- CmdOp  in  2  operation carried with SET_OP: 00 add, 01 sub, 10 mul, 11 div.
- keyOut  in  16  keypad value bus, shared with the AU; bits [7:0] are sampled on LOAD_B.
- Ahigh_in  out  1  AU AHigh load strobe.
- Alow_in  out  1  AU ALow load strobe.
- LoadB  out  1  AU B load strobe.
- LoadResult  out  1  AU result/remainder load strobe.
- Start  out  1  AU multiplier/divider start.
- ClearEntry  out  1  AU operand-register clear, active high.
- Clear  out  1  AU result-register clear, active high.
- Operations  out  2  AU operation select, held between SET_OP commands.
- Busy  out  1  high in START, WAIT and LOAD.
- ResultValid  out  1  high in SHOW.
- Error  out  1  one-cycle pulse for a rejected command.

Behaviour:
- All outputs are registered. Every strobe is exactly one cycle wide and asserts in the cycle after the command is accepted.
- Reset (Clear_n low at an edge):
  - state=ENTRY; flags a_set, b_set, op_set cleared; b_zero=0; Operations=00; counter=0.
  - Start, LoadResult, load strobes, Busy, ResultValid and Error all 0.
  - Clear=1 and ClearEntry=1; both fall at the first edge after Clear_n returns high.
- Reset mid-operation abandons the operation; no LoadResult is issued.
- States: ENTRY, START, WAIT, LOAD, SHOW.
- ENTRY and SHOW accept commands:
  - LOAD_AH: pulse Ahigh_in.
  - LOAD_AL: pulse Alow_in; a_set=1.
  - LOAD_B: pulse LoadB; b_set=1; b_zero=(keyOut[7:0]==0).
  - SET_OP: Operations<=CmdOp; op_set=1.
  - CE: pulse ClearEntry; a_set=b_set=0.
  - Any LOAD_*, SET_OP or CE issued from SHOW moves to ENTRY and drops ResultValid.
- EQUALS in ENTRY or SHOW:
  - If a_set, b_set and op_set are not all set: Error pulse, state unchanged.
  - Add/sub: go to LOAD. LoadResult is high in the cycle after EQUALS.
  - Mul/div: go to START. Start is high for one cycle; counter is loaded with MULT_LAT or DIV_LAT.
- WAIT: counter decrements each cycle; when it reaches 1, go to LOAD.
  - Mul: LoadResult asserts MULT_LAT+2 cycles after EQUALS acceptance.
- LOAD: LoadResult=1, then go to SHOW. ResultValid rises the following cycle.
- Busy handling:
  - CmdValid during START, WAIT or LOAD is ignored (no Error), except CLR.
  - CLR in any state: pulse Clear and ClearEntry together; clear all flags; go to ENTRY. Any in-flight wait is abandoned and LoadResult is suppressed.
  - CLR takes priority over a counter expiry in the same cycle.
- Cmd=7 in any state: Error pulse only.
- Operations does not change while Busy, so the AU result mux stays stable through LoadResult.
- Operand flags persist through SHOW, so EQUALS may be repeated. Chained operations reload only the operands that change.

Optional Feature:
- Macro: AU_DIV_ZERO_CHECK_EN.
- Defined: EQUALS with Operations=11 and b_zero=1 gives an Error pulse, no Start, and the state stays where it was. The AU keeps its previous Result.
- Undefined: b_zero is not implemented and divide-by-zero sequences normally. The AU output is then whatever its divider produces.

Test Plan:
- Reset, then LOAD_AL(keyOut=0x0005), LOAD_B(0x0003), SET_OP(00), EQUALS -> one-cycle Alow_in and LoadB pulses; LoadResult 1 cycle after EQUALS; ResultValid next cycle; AU Result=0x0008.
- SET_OP(10), A=0x0C, B=0x0B, EQUALS -> Start high 1 cycle; Busy high for 12 cycles; LoadResult at EQUALS+12 with default MULT_LAT; AU Result=0x0084.
- SET_OP(11), LOAD_AH(0x0000), LOAD_AL(0x0011), LOAD_B(0x0003), EQUALS -> LoadResult at EQUALS+22; AU Result=0x0005, Remainder_Result=0x0002.
- Division in progress, CLR issued on WAIT cycle 5 -> Clear and ClearEntry pulsed; no LoadResult; state ENTRY; a following EQUALS gives an Error pulse.
- EQUALS with only A loaded -> Error pulse; no Start or LoadResult. Cmd=7 -> Error pulse. LOAD_B while Busy -> no LoadB pulse.
- Macro defined: div with B=0x00, EQUALS -> Error pulse, no Start, ResultValid unchanged. Macro undefined: Start issued.
